// File: rtl/spi_wb_pkg.sv
// Shared definitions for the SPI-to-Wishbone target.
//   CMD_WRITE / CMD_READ : recognised command bytes
//   frame_state_t        : SPI frame decoder states
//   wb_state_t           : Wishbone master states
package spi_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDUMMY,
    RDATA,
    IGNORE
  } frame_state_t;

  typedef enum logic {
    WB_IDLE,
    WB_REQ
  } wb_state_t;

endpackage

// File: rtl/spi_target_sync_edge.sv
// Synchronises the SPI pins into the clk_i domain and produces single-cycle
// edge pulses.
//   clk_i, rst_i             : system clock, async active-low reset
//   sck_i, ss_n_i, mosi_i    : raw SPI pins
//   sck_rise, sck_fall       : synchronised sck edge pulses
//   ss_fall, ss_rise         : synchronised select edge pulses
//   ss_n_s, mosi_s           : synchronised levels
module spi_target_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  output logic sck_rise,
  output logic sck_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_n_s,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sr;
  logic [SYNC_STAGES-1:0] ss_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic                   sck_d;
  logic                   ss_d;

  // mosi goes through the same depth as sck so data and clock stay aligned
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sr  <= '0;
      ss_sr   <= '1;
      mosi_sr <= '0;
      sck_d   <= 1'b0;
      ss_d    <= 1'b1;
    end else begin
      sck_sr  <= {sck_sr[SYNC_STAGES-2:0], sck_i};
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], ss_n_i};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi_i};
      sck_d   <= sck_sr[SYNC_STAGES-1];
      ss_d    <= ss_sr[SYNC_STAGES-1];
    end
  end

  assign ss_n_s   = ss_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign sck_rise =  sck_sr[SYNC_STAGES-1] & ~sck_d;
  assign sck_fall = ~sck_sr[SYNC_STAGES-1] &  sck_d;
  assign ss_fall  = ~ss_sr[SYNC_STAGES-1]  &  ss_d;
  assign ss_rise  =  ss_sr[SYNC_STAGES-1]  & ~ss_d;

endmodule

// File: rtl/spi_to_wb_target.sv
// SPI mode-0 target bridging frames from an external master onto 8-bit
// classic Wishbone cycles.
//   clk_i, rst_i           : system clock, async active-low reset
//   sck_i, ss_n_i, mosi_i  : SPI inputs; miso_o / miso_oe_o : SPI output + pad enable
//   adr_o, dat_o, dat_i, we_o, cyc_o, stb_o, ack_i, err_i : Wishbone master
//   clr_i                  : clears ovr_o / err_o
//   busy_o                 : frame in progress
//   ovr_o, err_o           : sticky overrun / bus-error flags
// Frames: CMD, ADDR, then data (write 0x02) or dummy + data (read 0x03).
module spi_to_wb_target
  import spi_wb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RD_FILL     = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       ss_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o,
  output logic [7:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       we_o,
  output logic       cyc_o,
  output logic       stb_o,
  input  logic       ack_i,
  input  logic       err_i,
  input  logic       clr_i,
  output logic       busy_o,
  output logic       ovr_o,
  output logic       err_o
);

  logic sck_rise, sck_fall, ss_fall, ss_rise, ss_n_s, mosi_s;

  spi_target_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .sck_i    (sck_i),
    .ss_n_i   (ss_n_i),
    .mosi_i   (mosi_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .ss_fall  (ss_fall),
    .ss_rise  (ss_rise),
    .ss_n_s   (ss_n_s),
    .mosi_s   (mosi_s)
  );

  frame_state_t state_q, state_d;
  wb_state_t    wb_q, wb_d;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;     // bits still to be shifted; current bit lives in miso_q
  logic       miso_q;
  logic [7:0] addr_cnt;
  logic [7:0] rd_buf;
  logic       rd_valid;
  logic       is_read;
  logic       discard;
  logic       we_q;
  logic [7:0] dat_q;

  logic       active, byte_done, rd_boundary, wr_byte, wb_idle, wb_done;
  logic       rd_launch, wr_launch, launch, ovr_set, err_set;
  logic [7:0] rx_byte, tx_val;

  assign active      = (state_q != IDLE);
  assign byte_done   = active & sck_rise & ~ss_rise & (bit_cnt == 3'd7);
  assign rx_byte     = {rx_sr, mosi_s};
  assign rd_boundary = byte_done & ((state_q == RDUMMY) | (state_q == RDATA));
  assign wr_byte     = byte_done & (state_q == WDATA);
  assign wb_idle     = (wb_q == WB_IDLE);
  assign wb_done     = (wb_q == WB_REQ) & (ack_i | err_i);
  assign rd_launch   = (byte_done & (state_q == ADDR) & is_read) | (rd_boundary & rd_valid);
  assign wr_launch   = wr_byte;
  assign launch      = (rd_launch | wr_launch) & wb_idle;
  assign ovr_set     = (wr_byte & ~wb_idle) | (rd_boundary & ~rd_valid);
  assign err_set     = wb_done & err_i;

  always_comb begin
    state_d = state_q;
    if (ss_rise) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (ss_fall) state_d = CMD;
        CMD:     if (byte_done)
                   state_d = (rx_byte == CMD_WRITE || rx_byte == CMD_READ) ? ADDR : IGNORE;
        ADDR:    if (byte_done) state_d = is_read ? RDUMMY : WDATA;
        RDUMMY:  if (byte_done) state_d = RDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_val = '0;
    if (state_d == IGNORE)
      tx_val = RD_FILL;
    else if (rd_boundary)
      tx_val = rd_valid ? rd_buf : RD_FILL;
  end

  always_comb begin
    wb_d = wb_q;
    unique case (wb_q)
      WB_IDLE: if (launch) wb_d = WB_REQ;
      WB_REQ:  if (ack_i | err_i) wb_d = WB_IDLE;
      default: wb_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      wb_q    <= WB_IDLE;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_cnt  <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
      miso_q   <= 1'b1;
      addr_cnt <= '0;
      rd_buf   <= '0;
      rd_valid <= 1'b0;
      is_read  <= 1'b0;
      discard  <= 1'b0;
      we_q     <= 1'b0;
      dat_q    <= '0;
      ovr_o    <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (ss_rise | ss_fall) begin
        bit_cnt <= '0;
      end else if (active & sck_rise) begin
        rx_sr   <= rx_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state_q == CMD && byte_done)
        is_read <= (rx_byte == CMD_READ);

      // The fall right after a byte boundary must not shift: bit 7 of the
      // freshly loaded byte has to stay on the pin for the next rise.
      if (ss_n_s) begin
        miso_q <= 1'b1;
      end else if (ss_fall) begin
        tx_sr  <= '0;
        miso_q <= 1'b0;
      end else if (byte_done) begin
        tx_sr  <= tx_val[6:0];
        miso_q <= tx_val[7];
      end else if (active & sck_fall & (bit_cnt != 3'd0)) begin
        tx_sr  <= {tx_sr[5:0], 1'b0};
        miso_q <= tx_sr[6];
      end

      if (launch) begin
        we_q    <= wr_launch;
        discard <= 1'b0;
        if (wr_launch) dat_q <= rx_byte;
      end else if (wb_done) begin
        we_q <= 1'b0;
      end
      if (ss_rise && wb_q == WB_REQ)
        discard <= 1'b1;

      if (state_q == ADDR && byte_done)
        addr_cnt <= rx_byte;
      else if (wb_done)
        addr_cnt <= addr_cnt + 8'd1;

      if (ss_rise) begin
        rd_valid <= 1'b0;
      end else if (wb_done && !we_q && !discard) begin
        rd_buf   <= err_i ? RD_FILL : dat_i;
        rd_valid <= 1'b1;
      end else if (rd_boundary && rd_valid) begin
        rd_valid <= 1'b0;
      end

      if (ovr_set)    ovr_o <= 1'b1;
      else if (clr_i) ovr_o <= 1'b0;
      if (err_set)    err_o <= 1'b1;
      else if (clr_i) err_o <= 1'b0;
    end
  end

  assign miso_o    = miso_q;
  assign miso_oe_o = ~ss_n_s;
  assign busy_o    = ~ss_n_s;
  assign cyc_o     = (wb_q == WB_REQ);
  assign stb_o     = (wb_q == WB_REQ);
  assign adr_o     = addr_cnt;
  assign dat_o     = dat_q;
  assign we_o      = we_q;

endmodule

// File: tb/tb_spi_to_wb_target.sv
module tb_spi_to_wb_target;

  logic       clk = 1'b0;
  logic       rst_i, sck_i, ss_n_i, mosi_i, clr_i;
  logic       miso_o, miso_oe_o, we_o, cyc_o, stb_o, ack_i, err_i;
  logic       busy_o, ovr_o, err_o;
  logic [7:0] adr_o, dat_o, dat_i;

  always #5 clk = ~clk;

  spi_to_wb_target #(.SYNC_STAGES(2), .RD_FILL(8'hFF)) dut (
    .clk_i(clk), .rst_i(rst_i), .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .adr_o(adr_o), .dat_o(dat_o),
    .dat_i(dat_i), .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i),
    .err_i(err_i), .clr_i(clr_i), .busy_o(busy_o), .ovr_o(ovr_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       we;
    logic [7:0] adr;
    logic [7:0] dat;
  } wb_t;

  wb_t        log_q[$];
  logic [7:0] mem     [256];   // slave storage, written only by DUT cycles
  logic [7:0] ref_mem [256];   // reference register space
  logic [7:0] tx_bytes[$];
  logic [7:0] rx_bytes[$];
  int         lat      = 1;
  bit         err_mode = 1'b0;

  // Wishbone slave: responds after 'lat' cycles of cyc_o, logs every cycle
  initial begin
    int wcnt;
    wcnt = 0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk);
      if (ack_i || err_i) begin
        ack_i = 1'b0; err_i = 1'b0; wcnt = 0;
      end else if (cyc_o && stb_o) begin
        wcnt++;
        if (wcnt >= lat) begin
          dat_i = mem[adr_o];
          if (err_mode) err_i = 1'b1;
          else begin
            ack_i = 1'b1;
            if (we_o) mem[adr_o] = dat_o;
          end
          log_q.push_back('{we_o, adr_o, we_o ? dat_o : dat_i});
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi_i = tx[i];
      clk_wait(4);
      rx[i] = miso_o;
      sck_i = 1'b1;
      clk_wait(4);
      sck_i = 1'b0;
    end
  endtask

  task automatic run_frame();
    logic [7:0] b;
    rx_bytes.delete();
    ss_n_i = 1'b0;
    clk_wait(8);
    foreach (tx_bytes[i]) begin
      spi_bits(tx_bytes[i], 8, b);
      rx_bytes.push_back(b);
    end
    clk_wait(4);
    ss_n_i = 1'b1;
    clk_wait(8);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc_o && n < 500) begin clk_wait(1); n++; end
    clk_wait(4);
    total++;
    if (cyc_o !== 1'b0) begin
      bad++; $display("FAIL wb_idle_timeout: cyc_o=%b required 0", cyc_o);
    end
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1; clk_wait(1); clr_i = 1'b0; clk_wait(1);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; sck_i = 1'b0; ss_n_i = 1'b1; mosi_i = 1'b0; clr_i = 1'b0;
    clk_wait(3);
    total++;
    if ({miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o} !== 24'h800000) begin
      bad++; $display("FAIL reset_in: outs=%h required 800000",
        {miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o});
    end
    rst_i = 1'b1;
    clk_wait(5);
    total++;
    if ({miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o} !== 24'h800000) begin
      bad++; $display("FAIL reset_out: outs=%h required 800000",
        {miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o});
    end
  endtask

  task automatic test_write_basic();
    logic [7:0] exp_d[2];
    exp_d = '{8'hA5, 8'h5A};
    lat = 1; log_q.delete();
    tx_bytes = '{8'h02, 8'h10, 8'hA5, 8'h5A};
    run_frame(); wait_idle();
    total++;
    if (log_q.size() != 2) begin
      bad++; $display("FAIL wr_count: got %0d required 2", log_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (log_q[i].we !== 1'b1 || log_q[i].adr !== 8'(8'h10 + i) || log_q[i].dat !== exp_d[i]) begin
          bad++; $display("FAIL wr_entry%0d: we=%b adr=%h dat=%h required 1 %h %h",
            i, log_q[i].we, log_q[i].adr, log_q[i].dat, 8'(8'h10 + i), exp_d[i]);
        end
      end
    end
    total++;
    if (ovr_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL wr_flags: ovr=%b err=%b required 0 0", ovr_o, err_o);
    end
  endtask

  task automatic test_read_basic();
    logic [7:0] exp_rx[5];
    exp_rx = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'hC3};
    lat = 2; log_q.delete();
    mem[8'h20] = 8'h3C; mem[8'h21] = 8'hC3;
    tx_bytes = '{8'h03, 8'h20, 8'h00, 8'h00, 8'h00};
    run_frame(); wait_idle();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rx_bytes[i] !== exp_rx[i]) begin
        bad++; $display("FAIL rd_miso%0d: got %h required %h", i, rx_bytes[i], exp_rx[i]);
      end
    end
    total++;
    if (log_q.size() < 1 || log_q[0].we !== 1'b0 || log_q[0].adr !== 8'h20) begin
      bad++; $display("FAIL rd_first_cycle: entries=%0d required read at 20", log_q.size());
    end
    lat = 1;
  endtask

  task automatic test_wrap();
    logic [7:0] d0, d1;
    d0 = 8'($urandom); d1 = 8'($urandom);
    log_q.delete();
    tx_bytes = '{8'h02, 8'hFF, d0, d1};
    run_frame(); wait_idle();
    total++;
    if (log_q.size() != 2 || log_q[0].adr !== 8'hFF || log_q[1].adr !== 8'h00 ||
        log_q[0].dat !== d0 || log_q[1].dat !== d1) begin
      bad++; $display("FAIL wrap: entries=%0d required adr FF,00 dat %h,%h", log_q.size(), d0, d1);
    end
  endtask

  // ack held off longer than one SPI byte so the second data byte hits a busy bus
  task automatic test_holdoff();
    logic [7:0] d0, d1;
    d0 = 8'($urandom); d1 = 8'($urandom);
    lat = 100; log_q.delete();
    tx_bytes = '{8'h02, 8'h40, d0, d1};
    run_frame(); wait_idle();
    lat = 1;
    total++;
    if (log_q.size() != 1 || log_q[0].adr !== 8'h40 || log_q[0].dat !== d0) begin
      bad++; $display("FAIL holdoff_writes: entries=%0d required 1 write of %h at 40", log_q.size(), d0);
    end
    total++;
    if (ovr_o !== 1'b1) begin
      bad++; $display("FAIL holdoff_ovr: got %b required 1", ovr_o);
    end
    pulse_clr();
    total++;
    if (ovr_o !== 1'b0) begin
      bad++; $display("FAIL holdoff_clr: got %b required 0", ovr_o);
    end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    log_q.delete();
    ss_n_i = 1'b0; clk_wait(8);
    spi_bits(8'h02, 8, b);
    spi_bits(8'h55, 3, b);
    clk_wait(4); ss_n_i = 1'b1; clk_wait(20);
    total++;
    if (log_q.size() != 0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL abort_nocycle: entries=%0d busy=%b required 0 0", log_q.size(), busy_o);
    end
    tx_bytes = '{8'h02, 8'h30, 8'h11};
    run_frame(); wait_idle();
    total++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b1 || log_q[0].adr !== 8'h30 || log_q[0].dat !== 8'h11) begin
      bad++; $display("FAIL abort_next: entries=%0d required write 11 at 30", log_q.size());
    end
  endtask

  task automatic test_err();
    lat = 1; err_mode = 1'b1; log_q.delete();
    mem[8'h50] = 8'h12;
    tx_bytes = '{8'h03, 8'h50, 8'h00, 8'h00};
    run_frame(); wait_idle();
    err_mode = 1'b0;
    total++;
    if (rx_bytes[3] !== 8'hFF) begin
      bad++; $display("FAIL err_miso: got %h required FF", rx_bytes[3]);
    end
    total++;
    if (err_o !== 1'b1 || ovr_o !== 1'b0) begin
      bad++; $display("FAIL err_flag: err=%b ovr=%b required 1 0", err_o, ovr_o);
    end
    pulse_clr();
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("FAIL err_clr: got %b required 0", err_o);
    end
  endtask

  task automatic test_ignore();
    log_q.delete();
    tx_bytes = '{8'h7E, 8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(); clk_wait(10);
    for (int i = 1; i < 4; i++) begin
      total++;
      if (rx_bytes[i] !== 8'hFF) begin
        bad++; $display("FAIL ignore_miso%0d: got %h required FF", i, rx_bytes[i]);
      end
    end
    total++;
    if (log_q.size() != 0 || ovr_o !== 1'b0) begin
      bad++; $display("FAIL ignore_wb: entries=%0d ovr=%b required 0 0", log_q.size(), ovr_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    int n;
    bit rd;
    int diffs;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom); ref_mem[i] = mem[i];
    end
    for (int it = 0; it < 12; it++) begin
      a = 8'($urandom); n = $urandom_range(1, 4); rd = 1'($urandom);
      lat = $urandom_range(1, 4);
      log_q.delete();
      tx_bytes = '{rd ? 8'h03 : 8'h02, a};
      if (rd) tx_bytes.push_back(8'($urandom));
      for (int k = 0; k < n; k++) tx_bytes.push_back(8'($urandom));
      run_frame(); wait_idle();
      if (rd) begin
        for (int k = 0; k < n; k++) begin
          total++;
          if (rx_bytes[3+k] !== ref_mem[8'(a + k)]) begin
            bad++; $display("FAIL rand_rd it%0d byte%0d: got %h required %h",
              it, k, rx_bytes[3+k], ref_mem[8'(a + k)]);
          end
        end
      end else begin
        total++;
        if (log_q.size() != n) begin
          bad++; $display("FAIL rand_wr_count it%0d: got %0d required %0d", it, log_q.size(), n);
        end else begin
          for (int k = 0; k < n; k++) begin
            total++;
            if (log_q[k].we !== 1'b1 || log_q[k].adr !== 8'(a + k) || log_q[k].dat !== tx_bytes[2+k]) begin
              bad++; $display("FAIL rand_wr it%0d byte%0d: adr=%h dat=%h required %h %h",
                it, k, log_q[k].adr, log_q[k].dat, 8'(a + k), tx_bytes[2+k]);
            end
          end
        end
        for (int k = 0; k < n; k++) ref_mem[8'(a + k)] = tx_bytes[2+k];
      end
    end
    lat = 1;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    total++;
    if (diffs != 0) begin
      bad++; $display("FAIL rand_mem: %0d locations differ, required 0", diffs);
    end
    total++;
    if (ovr_o !== 1'b0 || err_o !== 1'b0) begin
      bad++; $display("FAIL rand_flags: ovr=%b err=%b required 0 0", ovr_o, err_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    ss_n_i = 1'b0; clk_wait(8);
    spi_bits(8'h02, 8, b);
    spi_bits(8'hAA, 4, b);
    rst_i = 1'b0;
    clk_wait(2);
    total++;
    if ({miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o} !== 24'h800000) begin
      bad++; $display("FAIL reset_mid: outs=%h required 800000",
        {miso_o, miso_oe_o, adr_o, dat_o, we_o, cyc_o, stb_o, busy_o, ovr_o, err_o});
    end
    ss_n_i = 1'b1; sck_i = 1'b0;
    clk_wait(2);
    rst_i = 1'b1;
    clk_wait(10);
    total++;
    if (busy_o !== 1'b0 || miso_o !== 1'b1 || cyc_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid_after: busy=%b miso=%b cyc=%b required 0 1 0", busy_o, miso_o, cyc_o);
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_wrap();
    test_holdoff();
    test_abort();
    test_err();
    test_ignore();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
